// File: rtl/sspi_byte_phy.sv
// SPI mode-3 slave byte PHY: oversampled pins, MOSI deserialiser, MISO serialiser, frame/error flags.
// rx_valid one cycle after the synchronised rise (no RX backpressure); TX through a one-deep holding register.
`timescale 1ns/100ps
module sspi_byte_phy #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       spi_csb,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso_out,
  output logic       spi_miso_oe,
  output logic       frame_start,
  output logic       frame_end,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       err_underrun,
  output logic       err_abort
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BLOCKED} state_t;

  logic [SYNC_STAGES-1:0] csb_sync, clk_sync, mosi_sync, settle;
  logic                   csb_s, clk_s, mosi_s, clk_d, settle_done;
  logic                   rise, fall;

  state_t     state;
  logic [2:0] bitcnt;
  logic       first_flag;
  logic [6:0] rx_shift;
  logic [7:0] hold, tx_shift;
  logic       hold_full;

  assign csb_s       = csb_sync[SYNC_STAGES-1];
  assign clk_s       = clk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign settle_done = settle[SYNC_STAGES-1];
  assign rise        = clk_s & ~clk_d;
  assign fall        = ~clk_s & clk_d;
  assign tx_ready    = ~hold_full;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csb_sync  <= '1;
      clk_sync  <= '1;
      mosi_sync <= '0;
      settle    <= '0;
      clk_d     <= 1'b1;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      settle    <= {settle[SYNC_STAGES-2:0], 1'b1};
      clk_d     <= clk_s;
    end
  end

  // Out of reset we sit in BLOCKED until the chains hold real pin samples;
  // a frame already in progress at that point is ignored until csb rises.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_BLOCKED;
      bitcnt       <= 3'd0;
      first_flag   <= 1'b0;
      rx_shift     <= 7'd0;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_first     <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      hold         <= 8'd0;
      hold_full    <= 1'b0;
      tx_shift     <= 8'd0;
      spi_miso_out <= 1'b0;
      spi_miso_oe  <= 1'b0;
      err_underrun <= 1'b0;
      err_abort    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      rx_valid    <= 1'b0;
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        S_BLOCKED: begin
          spi_miso_oe <= 1'b0;
          bitcnt      <= 3'd0;
          if (settle_done && csb_s) state <= S_IDLE;
        end
        S_IDLE: begin
          spi_miso_oe <= 1'b0;
          bitcnt      <= 3'd0;
          if (!csb_s) begin
            state        <= S_ACTIVE;
            frame_start  <= 1'b1;
            first_flag   <= 1'b1;
            // The opcode byte's response is don't-care, so an empty holding
            // register here is not an underrun; the clear wins.
            err_underrun <= 1'b0;
            err_abort    <= 1'b0;
            tx_shift     <= hold_full ? hold : IDLE_BYTE;
            hold_full    <= tx_valid;
            if (tx_valid) hold <= tx_data;
          end
        end
        S_ACTIVE: begin
          if (csb_s) begin
            state       <= S_IDLE;
            frame_end   <= 1'b1;
            spi_miso_oe <= 1'b0;
            bitcnt      <= 3'd0;
            hold_full   <= 1'b0;
            if (bitcnt != 3'd0) err_abort <= 1'b1;
          end else begin
            spi_miso_oe <= 1'b1;
            if (rise) begin
              rx_shift <= {rx_shift[5:0], mosi_s};
              bitcnt   <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                rx_valid   <= 1'b1;
                rx_data    <= {rx_shift, mosi_s};
                rx_first   <= first_flag;
                first_flag <= 1'b0;
                tx_shift   <= hold_full ? hold : IDLE_BYTE;
                if (!hold_full) err_underrun <= 1'b1;
                hold_full  <= tx_valid;
                if (tx_valid) hold <= tx_data;
              end
            end else if (fall) begin
              spi_miso_out <= tx_shift[7];
              tx_shift     <= {tx_shift[6:0], 1'b0};
            end
          end
        end
        default: state <= S_BLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_sspi_byte_phy.sv
// Bench for sspi_byte_phy: a bit-banged mode-3 master and a decoder-side TX feeder,
// checked against per-frame expectations derived from the byte/supply lists.
`timescale 1ns/100ps
module tb_sspi_byte_phy;

  localparam logic [7:0] IDLE = 8'h00;

  logic       clock, resetn;
  logic       spi_csb, spi_clk, spi_mosi;
  logic       spi_miso_out, spi_miso_oe;
  logic       frame_start, frame_end, rx_valid, rx_first;
  logic [7:0] rx_data, tx_data;
  logic       tx_valid, tx_ready, err_underrun, err_abort;

  int n_checks = 0;
  int n_errors = 0;
  int fs_cnt = 0;
  int fe_cnt = 0;
  logic [8:0] rx_got_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] sup_q[$];
  logic [7:0] miso_sh;

  sspi_byte_phy #(.SYNC_STAGES(2), .IDLE_BYTE(IDLE)) dut (
    .clock(clock), .resetn(resetn),
    .spi_csb(spi_csb), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso_out(spi_miso_out), .spi_miso_oe(spi_miso_oe),
    .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_first(rx_first),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .err_underrun(err_underrun), .err_abort(err_abort)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_valid) rx_got_q.push_back({rx_first, rx_data});
    if (frame_start) fs_cnt++;
    if (frame_end) fe_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One spi_clk level; optionally a 1 ns glitch placed clear of any clock edge.
  task automatic level(input real half, input bit glitchy);
    realtime t0;
    t0 = $realtime;
    if (glitchy && $urandom_range(0, 15) == 0) begin
      #3;
      @(posedge clock);
      #2 spi_clk = ~spi_clk;
      #1 spi_clk = ~spi_clk;
      #(t0 + half - $realtime);
    end else begin
      #(half);
    end
  endtask

  task automatic send_bit(input logic b, input real half, input bit glitchy);
    spi_clk  = 1'b0;
    spi_mosi = b;
    level(half, glitchy);
    spi_clk = 1'b1;
    miso_sh = {miso_sh[6:0], spi_miso_out};
    level(half, glitchy);
  endtask

  // Frame of mosi_q full bytes plus 'part' extra bits; sup_q is offered to
  // the TX side whenever tx_ready is high.
  task automatic run_frame(input int part, input real half, input bit glitchy);
    int n, m, rx0, fs0, fe0;
    bit stop;
    logic [7:0] exp_b;
    logic [8:0] e;
    n = mosi_q.size(); m = sup_q.size();
    rx0 = rx_got_q.size(); fs0 = fs_cnt; fe0 = fe_cnt;
    stop = 1'b0;
    fork
      begin : drv
        int idx = 0;
        while (!stop) begin
          @(negedge clock);
          if (!stop && tx_ready && idx < m) begin
            tx_valid = 1'b1;
            tx_data  = sup_q[idx];
            idx++;
          end else begin
            tx_valid = 1'b0;
          end
        end
        tx_valid = 1'b0;
      end
      begin : mst
        repeat (4) @(posedge clock);
        #2.5 spi_csb = 1'b0;
        #40;
        for (int k = 0; k < n; k++) begin
          for (int i = 7; i >= 0; i--) send_bit(mosi_q[k][i], half, glitchy);
          if (!glitchy) begin
            exp_b = (k < m) ? sup_q[k] : IDLE;
            check("miso_byte", 32'(miso_sh), 32'(exp_b));
          end
          if (k == 0) check("oe_in_frame", 32'(spi_miso_oe), 32'd1);
        end
        for (int i = 0; i < part; i++) send_bit(1'($urandom_range(0, 1)), half, glitchy);
        #40 stop = 1'b1;
        #20 spi_csb = 1'b1;
        repeat (6) @(posedge clock);
        #1;
      end
    join
    check("rx_count", 32'(rx_got_q.size() - rx0), 32'(n));
    for (int k = 0; k < n && rx0 + k < rx_got_q.size(); k++) begin
      e = {(k == 0), mosi_q[k]};
      check("rx_byte_first", 32'(rx_got_q[rx0 + k]), 32'(e));
    end
    check("frame_start_cnt", 32'(fs_cnt - fs0), 32'd1);
    check("frame_end_cnt", 32'(fe_cnt - fe0), 32'd1);
    check("err_underrun", 32'(err_underrun), 32'(n >= 1 && m <= n));
    check("err_abort", 32'(err_abort), 32'(part != 0));
    check("oe_idle", 32'(spi_miso_oe), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, 32'(spi_miso_out), 32'd0);
    check({tag, "_oe"}, 32'(spi_miso_oe), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_pulses"}, 32'({frame_start, frame_end, rx_valid}), 32'd0);
    check({tag, "_errs"}, 32'({err_underrun, err_abort}), 32'd0);
  endtask

  initial begin
    int fs1, fe1, rx1, n, p, m;
    resetn = 1'b0; spi_csb = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'd0; miso_sh = 8'd0;
    #23;
    check_reset_outputs("rst");
    resetn = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    check_reset_outputs("post_rst");

    // Opcode + one data byte with enough TX supply for every boundary
    mosi_q = {8'h21, 8'hA5}; sup_q = {8'h3C, 8'h81, 8'h55};
    run_frame(0, 50.0, 1'b0);

    // Second byte has no supply: IDLE byte on MISO and a sticky underrun
    mosi_q = {8'h12, 8'h34}; sup_q = {8'h3C};
    run_frame(0, 50.0, 1'b0);
    repeat (20) @(posedge clock);
    #1 check("underrun_sticky", 32'(err_underrun), 32'd1);

    // Partial trailing byte aborts the frame
    mosi_q = {8'h5A}; sup_q = {8'h11, 8'h22};
    run_frame(5, 50.0, 1'b0);

    // Reset pulse mid-byte with csb held low
    @(posedge clock);
    #2.5 spi_csb = 1'b0;
    #40;
    send_bit(1'b0, 50.0, 1'b0); send_bit(1'b0, 50.0, 1'b0); send_bit(1'b1, 50.0, 1'b0);
    #10 resetn = 1'b0;
    #7 check_reset_outputs("mid_rst");
    #10 resetn = 1'b1;
    fs1 = fs_cnt; fe1 = fe_cnt; rx1 = rx_got_q.size();
    for (int i = 0; i < 13; i++) send_bit(1'b1, 50.0, 1'b0);
    #40 spi_csb = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("blocked_rx", 32'(rx_got_q.size() - rx1), 32'd0);
    check("blocked_fs", 32'(fs_cnt - fs1), 32'd0);
    check("blocked_fe", 32'(fe_cnt - fe1), 32'd0);
    mosi_q = {8'h20}; sup_q = {};
    run_frame(0, 50.0, 1'b0);

    // Randomised frames
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(0, 3);
      p = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      m = $urandom_range(0, n + 1);
      mosi_q = {}; sup_q = {};
      for (int k = 0; k < n; k++) mosi_q.push_back(8'($urandom));
      for (int k = 0; k < m; k++) sup_q.push_back(8'($urandom));
      run_frame(p, 50.0, 1'b0);
    end

    // Fast clock with occasional sub-cycle glitches
    mosi_q = {}; sup_q = {};
    for (int k = 0; k < 32; k++) mosi_q.push_back(8'(k));
    for (int k = 0; k < 33; k++) sup_q.push_back(8'($urandom));
    run_frame(0, 17.0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
